alu_issue: RTL and testbench

Issue stage sitting directly upstream of the 16-function ALU. It buffers decoded operations (5-bit opcode plus two 32-bit operands) from operand fetch in a small FIFO and drives the ALU's opcode, a, b and enable inputs. Single-cycle functions issue one per cycle. Multiply and floating-point functions are held stable on the ALU inputs for a fixed number of cycles. Illegal opcodes are dropped and flagged.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_issue_fifo.sv | 62 ++++++
 rtl/alu_issue.sv | 125 ++++++++++++
 tb/tb_alu_issue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: opcodes, queued-operation record, issue FSM states.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADC  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SBB  = 5'd3;
  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam logic [4:0] OP_FADD = 5'd5;
  localparam logic [4:0] OP_FSUB = 5'd6;
  localparam logic [4:0] OP_FMUL = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_NAND = 5'd11;
  localparam logic [4:0] OP_NOR  = 5'd12;
  localparam logic [4:0] OP_XNOR = 5'd13;
  localparam logic [4:0] OP_NOT  = 5'd14;
  localparam logic [4:0] OP_NEG  = 5'd15;

  localparam logic [4:0] OP_LAST_LEGAL = 5'd15;

  // One decoded operation as it sits in the issue queue (69 bits).
  typedef struct packed {
    logic [4:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD
  } state_t;

  // Number of cycles an opcode must stay on the ALU inputs.
  function automatic int unsigned op_lat(input logic [4:0] opcode,
                                         input int unsigned mul_lat,
                                         input int unsigned fp_lat);
    case (opcode)
      OP_MUL, OP_FMUL:  return mul_lat;
      OP_FADD, OP_FSUB: return fp_lat;
      default:          return 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Issue queue: DEPTH x op_t circular buffer with synchronous clear.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored; full/count go to the producer.
module issue_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  op_t                      push_dat,
  input  logic                     pop,
  output op_t                      pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  op_t           mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr] <= push_dat;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: queues decoded ops and drives registered opcode/operands/enable to the ALU.
// Latency: push at edge t pops at edge t+1; ALU sees enable in the cycle after t+1.
// Backpressure: in_ready drops only when the queue is full; multi-cycle ops stall pops while held.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned FP_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_opcode,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_enable,
  output logic        busy,
  output logic        illegal
);

  localparam int unsigned HW = $clog2(MUL_LAT + FP_LAT + 1);

  state_t               state, state_n;
  logic [HW-1:0]        hold, hold_n;
  op_t                  alu_n;
  logic                 enable_n;
  logic                 illegal_n;
  logic                 pop;
  op_t                  head;
  op_t                  in_op;
  logic [$clog2(DEPTH):0] count;
  logic                 full;
  logic                 empty;
  int unsigned          head_lat;

  assign in_op    = '{opcode: in_opcode, a: in_a, b: in_b};
  assign in_ready = ~full;
  assign busy     = alu_enable | (count != '0);
  assign head_lat = op_lat(head.opcode, MUL_LAT, FP_LAT);

  issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .push     (in_valid & ~flush),
    .push_dat (in_op),
    .pop      (pop),
    .pop_dat  (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Next-state and next-output selection: pop the head when not holding a multi-cycle op.
  always_comb begin
    state_n   = state;
    hold_n    = hold;
    alu_n     = '{opcode: alu_opcode, a: alu_a, b: alu_b};
    enable_n  = alu_enable;
    illegal_n = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE, ST_ISSUE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.opcode > OP_LAST_LEGAL) begin
            // Dropped op still burns this issue slot.
            illegal_n = 1'b1;
            enable_n  = 1'b0;
            state_n   = ST_IDLE;
          end else begin
            alu_n    = head;
            enable_n = 1'b1;
            hold_n   = HW'(head_lat - 1);
            state_n  = (head_lat > 1) ? ST_HOLD : ST_ISSUE;
          end
        end else begin
          enable_n = 1'b0;
          state_n  = ST_IDLE;
        end
      end
      ST_HOLD: begin
        hold_n = hold - 1'b1;
        if (hold == HW'(1)) state_n = ST_ISSUE;
      end
      default: begin
        state_n  = ST_IDLE;
        enable_n = 1'b0;
      end
    endcase
  end

  // State and ALU-facing registers; flush abandons queued and in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hold       <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_enable <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      state      <= ST_IDLE;
      hold       <= '0;
      alu_enable <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state      <= state_n;
      hold       <= hold_n;
      alu_opcode <= alu_n.opcode;
      alu_a      <= alu_n.a;
      alu_b      <= alu_n.b;
      alu_enable <= enable_n;
      illegal    <= illegal_n;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: issue ordering, hold lengths, backpressure, illegal drop, flush, reset.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: stimulus offers ops and observes in_ready directly.
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_enable;
  logic        busy;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  alu_issue #(.DEPTH(4), .MUL_LAT(3), .FP_LAT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_enable (alu_enable),
    .busy       (busy),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
  endtask

  task automatic issued(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    check({tag, "_en"}, alu_enable, 1);
    check({tag, "_op"}, alu_opcode, op);
    check({tag, "_a"},  alu_a, a);
    check({tag, "_b"},  alu_b, b);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_opcode = '0; in_a = '0; in_b = '0;

    // Reset values
    step();
    check("rst_op", alu_opcode, 0);
    check("rst_a", alu_a, 0);
    check("rst_b", alu_b, 0);
    check("rst_en", alu_enable, 0);
    check("rst_ill", illegal, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy", in_ready, 1);
    #2 rst_n = 1'b1;
    step();

    // Back-to-back single-cycle ops
    offer(5'd0, 32'd5, 32'd3);
    step();
    check("b2b_wait_en", alu_enable, 0);
    offer(5'd8, 32'hF0, 32'h3C);
    step();
    issued("b2b_add", 5'd0, 32'd5, 32'd3);
    in_valid = 1'b0;
    step();
    issued("b2b_and", 5'd8, 32'hF0, 32'h3C);
    step();
    check("b2b_done_en", alu_enable, 0);
    check("b2b_done_busy", busy, 0);
    check("b2b_retain_op", alu_opcode, 8);

    // MUL held for 3 cycles, then OR
    offer(5'd4, 32'd7, 32'd6);
    step();
    offer(5'd9, 32'd1, 32'd2);
    step();
    issued("mul_c1", 5'd4, 32'd7, 32'd6);
    in_valid = 1'b0;
    step();
    issued("mul_c2", 5'd4, 32'd7, 32'd6);
    step();
    issued("mul_c3", 5'd4, 32'd7, 32'd6);
    step();
    issued("or_c4", 5'd9, 32'd1, 32'd2);
    step();
    check("or_done_en", alu_enable, 0);

    // Full FIFO: two MULs followed by a stream of SUBs
    offer(5'd4, 32'd1, 32'd0);       // E1 push M1
    step();
    offer(5'd4, 32'd2, 32'd0);       // E2 pop M1, push M2
    step();
    offer(5'd2, 32'd11, 32'd0);      // E3 push p1
    step();
    offer(5'd2, 32'd12, 32'd0);      // E4 push p2
    step();
    offer(5'd2, 32'd13, 32'd0);      // E5 pop M2, push p3
    step();
    issued("full_m2", 5'd4, 32'd2, 32'd0);
    check("full_rdy_e5", in_ready, 1);
    offer(5'd2, 32'd14, 32'd0);      // E6 push p4 -> count 4
    step();
    check("full_rdy_e6", in_ready, 0);
    offer(5'd2, 32'd15, 32'd0);      // p5 waits
    step();                          // E7 hold expires, no push
    check("full_rdy_e7", in_ready, 0);
    check("full_m2_c3", alu_opcode, 4);
    step();                          // E8 pop p1, still no push
    issued("full_p1", 5'd2, 32'd11, 32'd0);
    check("full_rdy_e8", in_ready, 1);
    step();                          // E9 pop p2, push p5
    issued("full_p2", 5'd2, 32'd12, 32'd0);
    in_valid = 1'b0;
    step();
    check("full_p3_a", alu_a, 13);
    step();
    check("full_p4_a", alu_a, 14);
    step();
    issued("full_p5", 5'd2, 32'd15, 32'd0);
    step();
    check("full_done_en", alu_enable, 0);

    // Illegal opcode dropped, following XOR still issues
    offer(5'd17, 32'hAA, 32'hBB);
    step();
    offer(5'd10, 32'd3, 32'd5);
    step();
    check("ill_pulse", illegal, 1);
    check("ill_en", alu_enable, 0);
    in_valid = 1'b0;
    step();
    check("ill_clear", illegal, 0);
    issued("ill_xor", 5'd10, 32'd3, 32'd5);
    step();
    check("ill_done_en", alu_enable, 0);
    check("ill_done_busy", busy, 0);

    // Flush during FMUL hold with ops queued and one offered
    offer(5'd7, 32'd100, 32'd200);
    step();                          // push FMUL
    offer(5'd0, 32'd21, 32'd0);
    step();                          // pop FMUL, push x1
    check("fl_fmul_op", alu_opcode, 7);
    offer(5'd1, 32'd22, 32'd0);
    step();                          // push x2
    offer(5'd3, 32'd23, 32'd0);
    flush = 1'b1;
    step();                          // flush, x3 dropped
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_en", alu_enable, 0);
    check("fl_busy", busy, 0);
    check("fl_rdy", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("fl_quiet_en", alu_enable, 0);
      check("fl_quiet_busy", busy, 0);
    end

    // Asynchronous reset during MUL hold
    offer(5'd4, 32'd9, 32'd9);
    step();
    in_valid = 1'b0;
    step();
    check("ar_hold_en", alu_enable, 1);
    #3 rst_n = 1'b0;
    #1;
    check("ar_en", alu_enable, 0);
    check("ar_op", alu_opcode, 0);
    check("ar_a", alu_a, 0);
    check("ar_b", alu_b, 0);
    check("ar_busy", busy, 0);
    check("ar_rdy", in_ready, 1);
    check("ar_ill", illegal, 0);
    #2 rst_n = 1'b1;
    offer(5'd0, 32'd11, 32'd22);
    step();
    in_valid = 1'b0;
    check("ar_new_wait", alu_enable, 0);
    step();
    issued("ar_new_add", 5'd0, 32'd11, 32'd22);
    step();
    check("ar_new_done", alu_enable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
